// File: rtl/aes_pkg.sv
// aes_pkg - shared AES definitions for the iterative AES-256 encryptor and decryptor.
//   Contents: FSM state enum, block/key/round constants, Rcon table, forward
//   S-box table, and the GF(2^8) helpers xtime/mixcol.
//   Byte/word ordering: byte 0 / word 0 sit in the most significant bits of
//   each vector, so FIPS-197 hex strings map directly onto literals.
package aes_pkg;

  localparam int NR    = 14;   // AES-256 round count, fixed by the standard
  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // AES-256 key expansion only consumes Rcon[1..7].
  localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x (i.e. 0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns on one column; row 0 byte in bits [31:24].
  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox - combinational forward AES S-box lookup.
//   in_byte  in  8  byte to substitute
//   out_byte out 8  S-box(in_byte)
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes256_encrypt_iter.sv
// aes256_encrypt_iter - iterative AES-256 encryptor, one round per clock,
//   on-the-fly key expansion. 14 clocks from accepted start to done.
// Ports:
//   clk      in   1    rising-edge clock
//   rst      in   1    synchronous active-high reset
//   Msg_in   in   128  plaintext, byte 0 in bits [127:120] (FIPS bit 0 = MSB)
//   key0     in   256  cipher key, word w0 in bits [255:224]
//   start    in   1    level request, acted on at its rising edge
//   Msg_out  out  128  ciphertext, valid while done=1
//   done     out  1    result ready, held until next accepted start or rst
// Build option:
//   AES_RESTART_EN - when defined, a start rising edge during RUN aborts the
//                    current block and reloads from Msg_in/key0.
module aes256_encrypt_iter
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BLK_W-1:0] Msg_in,
  input  logic [KEY_W-1:0] key0,
  input  logic             start,
  output logic [BLK_W-1:0] Msg_out,
  output logic             done
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  aes_state_e       state_q, state_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [KEY_W-1:0] keywin_q, keywin_d;
  logic [BLK_W-1:0] msg_out_q, msg_out_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic             accept;

  // ---------------- round datapath ----------------
  logic [7:0]       sb [16];
  logic [BLK_W-1:0] shifted, mixed, round_out;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_sub
      localparam int R = gi % 4;
      localparam int C = gi / 4;
      aes_sbox u_sbox (
        .in_byte (blk_q[127-8*gi -: 8]),
        .out_byte(sb[gi])
      );
      // ShiftRows: row R rotates left by R columns.
      assign shifted[127-8*gi -: 8] = sb[R + 4*((C + R) % 4)];
    end
    for (gi = 0; gi < 4; gi++) begin : g_mix
      assign mixed[127-32*gi -: 32] = mixcol(shifted[127-32*gi -: 32]);
    end
  endgenerate

  // keywin holds rk[rnd-1] (upper half) and rk[rnd] (lower half).
  assign round_out = ((rnd_q == LAST_RND) ? shifted : mixed) ^ keywin_q[127:0];

  // ---------------- key expansion ----------------
  logic [7:0]  sw [4];
  logic [31:0] sub_word, temp_word;
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  rnd_inc;
  logic [2:0]  rcon_idx;
  logic [7:0]  rcon_byte;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_byte (keywin_q[31-8*gi -: 8]),
        .out_byte(sw[gi])
      );
    end
  endgenerate

  assign sub_word = {sw[0], sw[1], sw[2], sw[3]};
  assign rnd_inc  = rnd_q + 4'd1;
  assign rcon_idx = rnd_inc[3:1];
  assign rcon_byte = (rcon_idx == 3'd0) ? 8'h00 : RCON[rcon_idx];

  // Odd rounds generate words 8i..8i+3 (RotWord+SubWord+Rcon); even rounds
  // generate 8i+4..8i+7 (SubWord only). Rotation commutes with SubWord.
  assign temp_word = rnd_q[0] ? ({sub_word[23:0], sub_word[31:24]} ^ {rcon_byte, 24'h0})
                              : sub_word;
  assign n0 = keywin_q[255:224] ^ temp_word;
  assign n1 = keywin_q[223:192] ^ n0;
  assign n2 = keywin_q[191:160] ^ n1;
  assign n3 = keywin_q[159:128] ^ n2;

  // ---------------- control ----------------
`ifdef AES_RESTART_EN
  assign accept = start & ~start_q;
`else
  assign accept = start & ~start_q & (state_q != RUN);
`endif

  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    keywin_d  = keywin_q;
    msg_out_d = msg_out_q;
    done_d    = done_q;
    start_d   = start;

    if (accept) begin
      state_d  = RUN;
      blk_d    = Msg_in ^ key0[255:128];
      keywin_d = key0;
      rnd_d    = 4'd1;
      done_d   = 1'b0;
    end else if (state_q == RUN) begin
      blk_d    = round_out;
      keywin_d = {keywin_q[127:0], n0, n1, n2, n3};
      rnd_d    = rnd_inc;
      if (rnd_q == LAST_RND) begin
        state_d   = DONE;
        rnd_d     = 4'd0;
        msg_out_d = round_out;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rnd_q     <= 4'd0;
      blk_q     <= '0;
      keywin_q  <= '0;
      msg_out_q <= '0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      blk_q     <= blk_d;
      keywin_q  <= keywin_d;
      msg_out_q <= msg_out_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

  assign Msg_out = msg_out_q;
  assign done    = done_q;

endmodule
